traffic_light_monitor: RTL

//  Receive-side checker for the 3-bit light_out bus of the traffic-light controller.

---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/tl_dwell_counter.sv | 27 ++
 rtl/traffic_light_monitor.sv | 124 ++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared light codes, phase encodings and FSM states for the traffic-light controller and its monitor.
// The helper functions decode an observed light code and give the legal phase order.
package traffic_pkg;

  localparam logic [2:0] LIGHT_MAIN_G = 3'b001;
  localparam logic [2:0] LIGHT_MAIN_Y = 3'b010;
  localparam logic [2:0] LIGHT_CROSS  = 3'b100;

  typedef enum logic [1:0] {
    PH_MAIN_G = 2'd0,
    PH_MAIN_Y = 2'd1,
    PH_CROSS  = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_MAIN_G,
    ST_MAIN_Y,
    ST_CROSS
  } state_e;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == LIGHT_MAIN_G) || (code == LIGHT_MAIN_Y) || (code == LIGHT_CROSS);
  endfunction

  function automatic state_e code_to_state(input logic [2:0] code);
    case (code)
      LIGHT_MAIN_G: return ST_MAIN_G;
      LIGHT_MAIN_Y: return ST_MAIN_Y;
      LIGHT_CROSS:  return ST_CROSS;
      default:      return ST_SYNC;
    endcase
  endfunction

  function automatic state_e next_in_order(input state_e s);
    case (s)
      ST_MAIN_G: return ST_MAIN_Y;
      ST_MAIN_Y: return ST_CROSS;
      ST_CROSS:  return ST_MAIN_G;
      default:   return ST_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// Saturating dwell counter: reloads to 1 when the observed code changes, otherwise counts up.
// at_threshold is high while the count is at or above the supplied threshold.
module tl_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reload,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count,
  output logic             at_threshold
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (reload) begin
      count <= CNT_W'(1);
    end else if (count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_threshold = (count >= threshold);

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the controller's light bus: locks onto the phase sequence,
// checks order and dwell time of each phase, and counts completed light cycles.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN_CYC  = 5,
  parameter int MAIN_YELLOW_CYC = 3,
  parameter int CROSS_CYC       = 8,
  parameter int DWELL_TOL       = 0,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  light_in,
  input  logic        clear,
  output logic [1:0]  phase,
  output logic        phase_valid,
  output logic        dwell_err,
  output logic        seq_err,
  output logic        illegal_code,
  output logic        err_sticky,
  output logic [15:0] cycle_count
);

  logic [2:0]       light_q;
  state_e           state, state_nx, new_state;
  logic             checked, checked_nx;
  logic             long_seen, long_nx;
  logic             change;
  logic             dwell_nx, seq_nx, ill_nx, cyc_inc;
  logic [CNT_W-1:0] dwell_cnt, long_thr;
  logic             at_long;
  int               req;

  assign change = (light_in != light_q);

  tl_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk          (clk),
    .reset_n      (reset_n),
    .reload       (change),
    .threshold    (long_thr),
    .count        (dwell_cnt),
    .at_threshold (at_long)
  );

  always_comb begin
    case (state)
      ST_MAIN_G: req = MAIN_GREEN_CYC;
      ST_MAIN_Y: req = MAIN_YELLOW_CYC;
      ST_CROSS:  req = CROSS_CYC;
      default:   req = 0;
    endcase
    long_thr = CNT_W'(req + DWELL_TOL);
  end

  // The phase entered straight out of SYNC is partial, so its dwell is never judged (checked=0).
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    checked_nx = checked;
    long_nx    = long_seen;
    dwell_nx   = 1'b0;
    seq_nx     = 1'b0;
    ill_nx     = 1'b0;
    cyc_inc    = 1'b0;
    new_state  = code_to_state(light_in);
    if (change) begin
      long_nx = 1'b0;
      if (!is_legal(light_in)) begin
        ill_nx     = 1'b1;
        state_nx   = ST_SYNC;
        checked_nx = 1'b0;
      end else if (state == ST_SYNC) begin
        state_nx   = new_state;
        checked_nx = 1'b0;
      end else begin
        seq_nx     = (new_state != next_in_order(state));
        dwell_nx   = checked && !long_seen && (int'(dwell_cnt) < req - DWELL_TOL);
        cyc_inc    = (state == ST_CROSS) && (new_state == ST_MAIN_G);
        state_nx   = new_state;
        checked_nx = 1'b1;
      end
    end else if (state != ST_SYNC && checked && !long_seen && at_long) begin
      // Count is about to pass REQ+TOL: report the overlong phase exactly once.
      dwell_nx = 1'b1;
      long_nx  = 1'b1;
    end
  end

  // NOTE: only control/status registers exist here, and all of them take the async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      light_q      <= 3'b000;
      state        <= ST_SYNC;
      checked      <= 1'b0;
      long_seen    <= 1'b0;
      dwell_err    <= 1'b0;
      seq_err      <= 1'b0;
      illegal_code <= 1'b0;
      err_sticky   <= 1'b0;
      cycle_count  <= 16'd0;
    end else begin
      light_q      <= light_in;
      state        <= state_nx;
      checked      <= checked_nx;
      long_seen    <= long_nx;
      dwell_err    <= dwell_nx;
      seq_err      <= seq_nx;
      illegal_code <= ill_nx;
      err_sticky   <= dwell_nx | seq_nx | ill_nx | (err_sticky & ~clear);
      if (cyc_inc) cycle_count <= cycle_count + 16'd1;
    end
  end

  always_comb begin
    phase_valid = (state != ST_SYNC);
    case (state)
      ST_MAIN_Y: phase = PH_MAIN_Y;
      ST_CROSS:  phase = PH_CROSS;
      default:   phase = PH_MAIN_G;
    endcase
  end

endmodule
